// File: rtl/watch_mode_ctrl.sv
// watch_mode_ctrl: watch master controller - debounced buttons, NORMAL/SETTING FSM with
// inactivity timeout, and 100 Hz / 2 Hz / 1 Hz tick enables plus a 1 Hz blink.
module watch_mode_ctrl #(
  parameter int CLK_HZ    = 1000000,
  parameter int NUM_POS   = 3,
  parameter int DB_CYCLES = 20000,
  parameter int TIMEOUT_S = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_mode,
  input  logic               btn_pos,
  input  logic               btn_inc,
  output logic               mode_out,
  output logic [NUM_POS-1:0] set_pos_out,
  output logic               inc_pulse,
  output logic               tick100hz,
  output logic               tick2hz,
  output logic               tick1hz,
  output logic               blink
);
  localparam int DIV = CLK_HZ / 100;
  localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int DW  = $clog2(DB_CYCLES + 1);
  localparam int TW  = TIMEOUT_S > 0 ? $clog2(TIMEOUT_S + 1) : 1;
  localparam logic [NUM_POS-1:0] POS_TOP = NUM_POS'(1) << (NUM_POS - 1);

  if (CLK_HZ % 100 != 0 || CLK_HZ < 100) begin : g_bad_clk
    $error("CLK_HZ must be a positive multiple of 100");
  end

  typedef enum logic {NORMAL, SETTING} state_t;

  logic [2:0] w_raw, r_s1, r_s2, w_press;
  logic [1:0] r_vld;
  assign w_raw = {btn_inc, btn_pos, btn_mode};

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_vld <= '0;
    end else begin
      r_s1  <= w_raw;
      r_s2  <= r_s1;
      r_vld <= {r_vld[0], 1'b1};
    end

  genvar b;
  for (b = 0; b < 3; b++) begin : g_db
    logic [DW-1:0] r_cnt;
    logic          r_stb, r_arm, w_done;
    assign w_done = r_cnt == DW'(DB_CYCLES);
    // a button held through reset must be seen low once before it can press again
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        r_cnt <= '0;
        r_stb <= 1'b0;
        r_arm <= 1'b0;
      end else begin
        r_cnt <= (r_s2[b] != r_stb && !w_done) ? r_cnt + 1'b1 : '0;
        if (w_done) r_stb <= r_s2[b];
        r_arm <= r_arm | (r_vld[1] & ~r_s2[b]);
      end
    assign w_press[b] = w_done & r_s2[b] & ~r_stb & r_arm;
  end

  logic [PW-1:0] r_pre;
  logic [5:0]    r_c50;
  logic          r_half, r_t100, r_t2, r_t1, w_w100, w_w2;
  assign w_w100 = r_pre == PW'(DIV - 1);
  assign w_w2   = w_w100 && r_c50 == 6'd49;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_pre  <= '0;
      r_c50  <= '0;
      r_half <= 1'b0;
      r_t100 <= 1'b0;
      r_t2   <= 1'b0;
      r_t1   <= 1'b0;
    end else begin
      r_pre  <= w_w100 ? '0 : r_pre + 1'b1;
      r_c50  <= w_w2 ? '0 : r_c50 + 6'(w_w100);
      r_half <= r_half ^ w_w2;
      r_t100 <= w_w100;
      r_t2   <= w_w2;
      r_t1   <= w_w2 & r_half;
    end

  state_t             r_state, w_state_n;
  logic [NUM_POS-1:0] r_pos, w_pos_n;
  logic [TW-1:0]      r_tmo, w_tmo_n;
  logic               r_inc, w_inc_n, w_at_limit;
  assign w_at_limit = r_tmo == TW'(TIMEOUT_S);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= NORMAL;
      r_pos   <= '0;
      r_tmo   <= '0;
      r_inc   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pos   <= w_pos_n;
      r_tmo   <= w_tmo_n;
      r_inc   <= w_inc_n;
    end

  always_comb begin
    w_state_n = r_state;
    w_pos_n   = r_pos;
    w_inc_n   = 1'b0;
    w_tmo_n   = '0;
    if (r_state == NORMAL) begin
      if (w_press[0]) begin
        w_state_n = SETTING;
        w_pos_n   = POS_TOP;
      end
    end else begin
      w_tmo_n = (|w_press) ? '0 : (r_t1 && !w_at_limit) ? r_tmo + 1'b1 : r_tmo;
      if (w_press[0]) w_state_n = NORMAL;
      else if (w_press[1]) w_pos_n = (r_pos >> 1) | (r_pos << (NUM_POS - 1));
      else if (w_press[2]) w_inc_n = 1'b1;
      else if (TIMEOUT_S != 0 && w_at_limit) w_state_n = NORMAL;
    end
  end

  assign mode_out    = r_state == SETTING;
  assign set_pos_out = mode_out ? r_pos : '0;
  assign inc_pulse   = r_inc;
  assign tick100hz   = r_t100;
  assign tick2hz     = r_t2;
  assign tick1hz     = r_t1;
  assign blink       = r_half;
endmodule

// File: tb/tb_watch_mode_ctrl.sv
// tb_watch_mode_ctrl: directed bench for watch_mode_ctrl with CLK_HZ=1000, DB_CYCLES=4,
// TIMEOUT_S=2, NUM_POS=3; inputs driven and outputs sampled on the falling edge.
module tb_watch_mode_ctrl;
  logic       clk = 1'b0, reset = 1'b1, btn_mode = 1'b0, btn_pos = 1'b0, btn_inc = 1'b0;
  logic       mode_out, inc_pulse, tick100hz, tick2hz, tick1hz, blink, seen;
  logic [2:0] set_pos_out;
  logic [8:0] all_o;
  int         cyc, n_inc, n_chk, n_fail, base, s, e, t2, n;

  always #5 clk = ~clk;

  watch_mode_ctrl #(.CLK_HZ(1000), .NUM_POS(3), .DB_CYCLES(4), .TIMEOUT_S(2)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_pos(btn_pos), .btn_inc(btn_inc),
    .mode_out(mode_out), .set_pos_out(set_pos_out), .inc_pulse(inc_pulse),
    .tick100hz(tick100hz), .tick2hz(tick2hz), .tick1hz(tick1hz), .blink(blink)
  );

  assign all_o = {mode_out, set_pos_out, inc_pulse, tick100hz, tick2hz, tick1hz, blink};

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;

  always @(posedge clk) if (inc_pulse) n_inc <= n_inc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] b, input int len);
    {btn_inc, btn_pos, btn_mode} = b;
    step(len);
    {btn_inc, btn_pos, btn_mode} = 3'b000;
    step(12);
  endtask

  task automatic wait_exit();
    n = 0;
    while (mode_out && n < 4000) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    step(3);
    chk("reset_outs", 32'(all_o), 0);
    reset = 1'b0;
    for (int i = 1; i <= 2100; i++) begin
      step(1);
      chk("ticks", {tick100hz, tick2hz, tick1hz, blink},
          {cyc % 10 == 0, cyc % 500 == 0, cyc % 1000 == 0, (cyc / 500) % 2 == 1});
    end
    btn_mode = 1'b1;
    step(6);
    chk("mode_lat6", 32'(mode_out), 0);
    step(1);
    chk("mode_lat7", 32'(mode_out), 1);
    chk("pos_enter", 32'(set_pos_out), 3'b100);
    step(3);
    btn_mode = 1'b0;
    step(12);
    press(3'b010, 10);
    chk("pos_010", 32'(set_pos_out), 3'b010);
    press(3'b010, 10);
    chk("pos_001", 32'(set_pos_out), 3'b001);
    press(3'b010, 10);
    chk("pos_wrap", 32'(set_pos_out), 3'b100);
    press(3'b001, 10);
    chk("exit_mode", 32'(mode_out), 0);
    chk("exit_pos", 32'(set_pos_out), 0);
    press(3'b001, 10);
    chk("enter2", 32'(mode_out), 1);
    base = n_inc;
    btn_inc = 1'b1;
    step(3);
    btn_inc = 1'b0;
    step(12);
    chk("inc_glitch", n_inc - base, 0);
    press(3'b100, 10);
    chk("inc_setting", n_inc - base, 1);
    press(3'b001, 10);
    chk("exit2", 32'(mode_out), 0);
    base = n_inc;
    press(3'b100, 10);
    chk("inc_normal", n_inc - base, 0);
    press(3'b011, 10);
    chk("simul_mode", 32'(mode_out), 1);
    chk("simul_pos", 32'(set_pos_out), 3'b100);
    base = n_inc;
    press(3'b110, 10);
    chk("pos_beats_inc", 32'(set_pos_out), 3'b010);
    chk("inc_discard", n_inc - base, 0);
    press(3'b001, 10);
    chk("exit3", 32'(mode_out), 0);
    s = cyc;
    press(3'b001, 10);
    e = s + 7;
    t2 = ((e + 999) / 1000) * 1000 + 1000;
    chk("to_enter", 32'(mode_out), 1);
    wait_exit();
    chk("to_exit_cycle", cyc, t2 + 2);
    chk("to_exit_pos", 32'(set_pos_out), 0);
    s = cyc;
    press(3'b001, 10);
    e = s + 7;
    t2 = ((e + 999) / 1000) * 1000 + 1000;
    wait_cyc(t2 - 5);
    btn_pos = 1'b1;
    wait_cyc(t2 + 3);
    chk("press_beats_expiry", 32'(mode_out), 1);
    chk("press_expiry_pos", 32'(set_pos_out), 3'b010);
    step(2);
    btn_pos = 1'b0;
    wait_cyc(t2 + 1010);
    chk("timer_restarted", 32'(mode_out), 1);
    wait_exit();
    chk("to_exit2_cycle", cyc, t2 + 2002);
    press(3'b001, 10);
    chk("enter_pre_rst", 32'(mode_out), 1);
    btn_mode = 1'b1;
    step(2);
    reset = 1'b1;
    #1;
    chk("rst_async", 32'(all_o), 0);
    step(3);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      seen |= mode_out;
    end
    chk("rst_held_nopress", 32'(seen), 0);
    btn_mode = 1'b0;
    step(12);
    press(3'b001, 10);
    chk("rst_repress", 32'(mode_out), 1);
    chk("rst_repress_pos", 32'(set_pos_out), 3'b100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/watch_mode_ctrl.md
Name: watch_mode_ctrl

Overview:
Second-generation master controller for the digital watch. It owns mode selection, setting-position selection and time-base generation. Improvements over the first generation:
- All three push-buttons are synchronised and debounced into the single clk domain; buttons are never used as clocks.
- The number of setting positions is parametrised.
- A setting-mode inactivity timeout is added.
- The time base is produced as single-cycle enables (ticks) instead of divided clocks.

Parameters:
CLK_HZ, 1000000, input clock frequency in Hz; must be a multiple of 100 (elaboration error otherwise)
NUM_POS, 3, number of one-hot setting positions (MSB = hour, LSB = second for the default)
DB_CYCLES, 20000, consecutive stable cycles required to accept a button level change
TIMEOUT_S, 30, seconds without any button press in SETTING before automatic return to NORMAL; 0 disables the timeout

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_mode  input  1  raw mode button, asynchronous, active-high
btn_pos  input  1  raw position-advance button, asynchronous, active-high
btn_inc  input  1  raw increment button, asynchronous, active-high
mode_out  output  1  0 = NORMAL, 1 = SETTING
set_pos_out  output  NUM_POS  one-hot selected field in SETTING; all-zero in NORMAL
inc_pulse  output  1  one-cycle request to increment the selected field
tick100hz  output  1  one-cycle enable at 100 Hz
tick2hz  output  1  one-cycle enable at 2 Hz
tick1hz  output  1  one-cycle enable at 1 Hz
blink  output  1  1 Hz square wave, 50 % duty, for flashing the selected field

Behaviour:
- Reset (asserted): all outputs are 0. Sync flops, debounce counters, stable levels, prescalers and the timeout counter are cleared. FSM goes to NORMAL. Assertion mid-operation takes effect immediately.
- Button path, per button:
  - 2-flop synchroniser.
  - Debounce counter increments while the synced level differs from the stable level and clears otherwise.
  - When the count reaches DB_CYCLES, the stable level takes the synced value and the counter clears.
  - A 0->1 change of the stable level produces a one-cycle press pulse.
  - Press latency from the first raw-high clk edge: DB_CYCLES+2 or DB_CYCLES+3 cycles.
  - Glitches shorter than DB_CYCLES cycles produce no press.
  - Release is debounced the same way and produces no pulse.
- Prescaler:
  - Counts 0..CLK_HZ/100-1; tick100hz is asserted on the cycle the count wraps.
  - First tick100hz occurs CLK_HZ/100 cycles after reset release.
  - A second counter (0..49) of tick100hz gives tick2hz.
  - tick2hz toggles a flop: tick1hz asserts on every second tick2hz, and blink toggles on every tick2hz.
  - Coincident ticks are asserted in the same cycle.
- FSM states: NORMAL, SETTING.
  - NORMAL + mode press -> SETTING, set_pos = one-hot MSB, timeout counter cleared.
  - NORMAL: pos and inc presses are ignored; inc_pulse stays 0.
  - SETTING + mode press -> NORMAL.
  - SETTING + pos press -> set_pos rotates right one place; LSB wraps to MSB.
  - SETTING + inc press -> inc_pulse is high for exactly the next cycle.
  - SETTING: any press clears the timeout counter.
  - SETTING: each tick1hz increments the timeout counter. When it reaches TIMEOUT_S, the FSM returns to NORMAL on the next cycle (never, if TIMEOUT_S = 0).
- Simultaneous events:
  - Mode press beats pos and inc presses in the same cycle; the others are discarded.
  - Pos press beats inc press; inc is discarded.
  - A press and a timeout expiry in the same cycle: the press wins and the timer is cleared.
- Outputs are registered: mode_out and set_pos_out update one cycle after the press pulse. set_pos_out = mode_out ? set_pos : 0.
- Counter widths are derived via clog2 of each terminal count; no wrap beyond the terminal values.

Test Plan:
All scenarios use CLK_HZ=1000, DB_CYCLES=4, TIMEOUT_S=2, NUM_POS=3.
1. Free run 2100 cycles after reset ->
   - tick100hz at cycles 10, 20, ...
   - tick2hz at 500, 1000, 1500, 2000
   - tick1hz at 1000, 2000
   - blink rises at 500, falls at 1000
   - all pulses exactly one cycle wide
2. btn_mode held 10 cycles -> mode_out=1 and set_pos_out=100 within 7 cycles. Three btn_pos presses -> set_pos_out 010, 001, 100. btn_mode press -> mode_out=0, set_pos_out=000.
3. btn_inc 3-cycle glitch, then a 10-cycle press, in SETTING -> no pulse for the glitch, exactly one inc_pulse for the press. The same press in NORMAL -> no inc_pulse.
4. Enter SETTING and stay idle -> return to NORMAL after the second tick1hz following entry. Repeat with a btn_pos press just before expiry -> the timer restarts and the FSM is still SETTING.
5. btn_mode and btn_pos pressed together in NORMAL -> SETTING with set_pos_out=100 (pos discarded). btn_pos and btn_inc together in SETTING -> position advances, no inc_pulse.
6. Reset asserted mid-SETTING while btn_mode is held -> outputs are 0 immediately. After release, no press is generated until the button is released and pressed again.
